// File: rtl/matrix_tile_pkg.sv
// Shared types and index helpers for the matrix tile streamer.
// MATRIX_TILE_COL_MAJOR_EN (in matrix_tile_sel) selects column-major tile order.
package matrix_tile_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Index width that never collapses to zero bits when only one tile exists.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int mat_off(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

    function automatic int tile_off(input int i, input int j, input int t, input int w);
        return (i * t + j) * w;
    endfunction

endpackage

// File: rtl/matrix_tile_extract.sv
// Combinational selection of tile (tr,tc) out of a packed N x N matrix buffer.
module matrix_tile_extract
    import matrix_tile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N      = 64,
    parameter int T      = 16,
    localparam int K     = N / T,
    localparam int IW    = clog2_min1(K)
) (
    input  logic [N*N*DATA_W-1:0] buffer,
    input  logic [IW-1:0]         tr,
    input  logic [IW-1:0]         tc,
    output logic [T*T*DATA_W-1:0] tile
);

    // Straight bit copy; signed elements are never widened.
    always_comb begin
        tile = '0;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                tile[tile_off(i, j, T, DATA_W) +: DATA_W] =
                    buffer[mat_off(int'(tr) * T + i, int'(tc) * T + j, N, DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/matrix_tile_sel.sv
// Captures an N x N matrix on en and streams it as T x T tiles over valid/ready.
// Define MATRIX_TILE_COL_MAJOR_EN for column-major tile order (default row-major).
module matrix_tile_sel
    import matrix_tile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N      = 64,
    parameter int T      = 16,
    localparam int K     = N / T,
    localparam int IW    = clog2_min1(K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N*N*DATA_W-1:0] matrix,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic [T*T*DATA_W-1:0] tile_data,
    output logic [IW-1:0]         tile_row,
    output logic [IW-1:0]         tile_col,
    output logic                  busy,
    output logic                  finish,
    output logic                  state_dbg
);

    if (N % T != 0) begin : g_bad_tiling
        $error("matrix_tile_sel: N must be a multiple of T");
    end

    localparam logic [IW-1:0] LAST = IW'(K - 1);

    // Handshake: a tile transfers on any posedge where tile_valid && tile_ready;
    // while tile_valid is high and no transfer occurs, tile_data/row/col hold.
    state_t                  state_q, state_d;
    logic [N*N*DATA_W-1:0]   buf_q, buf_d;
    logic [IW-1:0]           tr_q, tr_d, tc_q, tc_d;
    logic [T*T*DATA_W-1:0]   data_q, data_d, ext_tile;
    logic                    finish_q, finish_d;
    logic                    last_tile;

    assign last_tile = (tr_q == LAST) && (tc_q == LAST);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        tr_d     = tr_q;
        tc_d     = tc_q;
        finish_d = finish_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    buf_d    = matrix;
                    tr_d     = '0;
                    tc_d     = '0;
                    finish_d = 1'b0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tile_ready) begin
                    if (last_tile) begin
                        finish_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
`ifdef MATRIX_TILE_COL_MAJOR_EN
                        if (tr_q == LAST) begin
                            tr_d = '0;
                            tc_d = tc_q + 1'b1;
                        end else begin
                            tr_d = tr_q + 1'b1;
                        end
`else
                        if (tc_q == LAST) begin
                            tc_d = '0;
                            tr_d = tr_q + 1'b1;
                        end else begin
                            tc_d = tc_q + 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Extract from the next-state buffer/indices so the new tile is registered
    // on the same edge as the capture or handshake that selects it.
    matrix_tile_extract #(
        .DATA_W(DATA_W),
        .N     (N),
        .T     (T)
    ) u_extract (
        .buffer(buf_d),
        .tr    (tr_d),
        .tc    (tc_d),
        .tile  (ext_tile)
    );

    assign data_d = (state_d == ST_SEND) ? ext_tile : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            tr_q     <= '0;
            tc_q     <= '0;
            data_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            tr_q     <= tr_d;
            tc_q     <= tc_d;
            data_q   <= data_d;
            finish_q <= finish_d;
        end
    end

    assign tile_valid = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND);
    assign tile_data  = data_q;
    assign tile_row   = tr_q;
    assign tile_col   = tc_q;
    assign finish     = finish_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_matrix_tile_sel.sv
// Directed bench for matrix_tile_sel: 64/16 stream, 8/4 backpressure, 2/2 single tile.
module tb_matrix_tile_sel;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: N=64, T=16, DATA_W=16
    logic           en, ready;
    logic [65535:0] matrix;
    logic           valid, busy, finish, dbg;
    logic [4095:0]  data;
    logic [1:0]     row, col;

    matrix_tile_sel #(.DATA_W(16), .N(64), .T(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .matrix(matrix),
        .tile_valid(valid), .tile_ready(ready), .tile_data(data),
        .tile_row(row), .tile_col(col), .busy(busy), .finish(finish),
        .state_dbg(dbg)
    );

    // Small instance: N=8, T=4, DATA_W=8
    logic         s_en, s_ready;
    logic [511:0] s_matrix;
    logic         s_valid, s_busy, s_finish, s_dbg;
    logic [127:0] s_data;
    logic [0:0]   s_row, s_col;

    matrix_tile_sel #(.DATA_W(8), .N(8), .T(4)) u_small (
        .clk(clk), .rst(rst), .en(s_en), .matrix(s_matrix),
        .tile_valid(s_valid), .tile_ready(s_ready), .tile_data(s_data),
        .tile_row(s_row), .tile_col(s_col), .busy(s_busy), .finish(s_finish),
        .state_dbg(s_dbg)
    );

    // Single-tile instance: N=T=2, DATA_W=8
    logic        o_en, o_ready;
    logic [31:0] o_matrix;
    logic        o_valid, o_busy, o_finish, o_dbg;
    logic [31:0] o_data;
    logic [0:0]  o_row, o_col;

    matrix_tile_sel #(.DATA_W(8), .N(2), .T(2)) u_one (
        .clk(clk), .rst(rst), .en(o_en), .matrix(o_matrix),
        .tile_valid(o_valid), .tile_ready(o_ready), .tile_data(o_data),
        .tile_row(o_row), .tile_col(o_col), .busy(o_busy), .finish(o_finish),
        .state_dbg(o_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [65535:0] mat_a, mat_b, mat_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tile(input string tag, input logic [4095:0] obs,
                            input logic [4095:0] exp, input int dw);
        int k;
        logic [63:0] ow, ew, mask;
        checks++;
        assert (obs === exp) else begin
            errors++;
            k = 0;
            for (int b = 4095; b >= 0; b--) if (obs[b] !== exp[b]) k = b / dw;
            mask = (64'd1 << dw) - 64'd1;
            ow = 64'(obs >> (k * dw)) & mask;
            ew = 64'(exp >> (k * dw)) & mask;
            $error("FAIL %s elem %0d got %0h expected %0h", tag, k, ow, ew);
        end
    endtask

    function automatic logic [4095:0] exp_tile(input logic [65535:0] m, input int n,
                                               input int t, input int dw,
                                               input int tr, input int tc);
        logic [4095:0] res;
        res = '0;
        for (int i = 0; i < t; i++)
            for (int j = 0; j < t; j++)
                for (int b = 0; b < dw; b++)
                    res[(i * t + j) * dw + b] = m[((tr * t + i) * n + tc * t + j) * dw + b];
        return res;
    endfunction

    function automatic int ord_r(input int n, input int k);
`ifdef MATRIX_TILE_COL_MAJOR_EN
        return n % k;
`else
        return n / k;
`endif
    endfunction

    function automatic int ord_c(input int n, input int k);
`ifdef MATRIX_TILE_COL_MAJOR_EN
        return n / k;
`else
        return n % k;
`endif
    endfunction

    // Streams all 16 tiles of the main instance with ready held high.
    task automatic stream_big(input logic [65535:0] expm, input int en_at,
                              input logic [65535:0] alt, input bit chk_1056);
        int etr, etc;
        ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            etr = ord_r(n, 4);
            etc = ord_c(n, 4);
            chk("valid", 64'(valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("row", 64'(row), 64'(etr));
            chk("col", 64'(col), 64'(etc));
            chk_tile("data", data, exp_tile(expm, 64, 16, 16, etr, etc), 16);
            if (chk_1056 && etr == 1 && etc == 2) chk("t12_e00", 64'(data[15:0]), 64'd1056);
            if (n == en_at) begin
                matrix = alt;
                en = 1'b1;
            end
            tick();
            en = 1'b0;
        end
        chk("finish_end", 64'(finish), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("valid_end", 64'(valid), 64'd0);
    endtask

    initial begin
        int idx, cyc, etr, etc;

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                mat_a[(r * 64 + c) * 16 +: 16] = 16'(r * 64 + c);
                mat_b[(r * 64 + c) * 16 +: 16] = 16'(r * 64 + c) ^ 16'h5a5a;
                mat_c[(r * 64 + c) * 16 +: 16] = 16'h8000;
            end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                s_matrix[(r * 8 + c) * 8 +: 8] = 8'(r * 8 + c - 20);
        o_matrix = 32'h807f01fe;

        // Reset values
        rst = 1'b1; en = 1'b0; ready = 1'b0; matrix = mat_a;
        s_en = 1'b0; s_ready = 1'b0; o_en = 1'b0; o_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_row", 64'(row), 64'd0);
        chk("rst_col", 64'(col), 64'd0);
        chk("rst_dbg", 64'(dbg), 64'd0);
        chk_tile("rst_data", data, '0, 16);
        rst = 1'b0;
        tick();
        chk("idle_valid", 64'(valid), 64'd0);

        // Stream A: element (r,c) = r*64+c
        matrix = mat_a; en = 1'b1;
        tick();
        en = 1'b0;
        chk("a_dbg", 64'(dbg), 64'd1);
        stream_big(mat_a, -1, mat_a, 1'b1);

        // Stream B with an ignored en of matrix C mid-stream
        matrix = mat_b; en = 1'b1;
        tick();
        en = 1'b0;
        chk("b_finish_clr", 64'(finish), 64'd0);
        stream_big(mat_b, 3, mat_c, 1'b0);

        // Back-to-back en right after finish: all-negative matrix C
        matrix = mat_c; en = 1'b1;
        tick();
        en = 1'b0;
        chk("c_finish_clr", 64'(finish), 64'd0);
        chk("c_e00", 64'(data[15:0]), 64'h8000);
        stream_big(mat_c, -1, mat_c, 1'b0);

        // Reset mid-stream after the 5th handshake
        matrix = mat_a; en = 1'b1;
        tick();
        en = 1'b0; ready = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        chk("mid_row", 64'(row), 64'(ord_r(5, 4)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 64'(valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_finish", 64'(finish), 64'd0);
        chk_tile("mr_data", data, '0, 16);
        tick(); tick(); tick();
        chk("mr_no_resume", 64'(valid), 64'd0);
        chk("mr_no_finish", 64'(finish), 64'd0);
        ready = 1'b0;

        // Small instance with ready pattern 1,0,0,1,0,0,...
        s_en = 1'b1;
        tick();
        s_en = 1'b0;
        idx = 0;
        cyc = 0;
        while (!s_finish && cyc < 40) begin
            s_ready = (cyc % 3 == 0);
            etr = ord_r(idx, 2);
            etc = ord_c(idx, 2);
            chk("s_valid", 64'(s_valid), 64'd1);
            chk("s_row", 64'(s_row), 64'(etr));
            chk("s_col", 64'(s_col), 64'(etc));
            chk_tile("s_data", 4096'(s_data), exp_tile(65536'(s_matrix), 8, 4, 8, etr, etc), 8);
            if (s_ready) idx++;
            tick();
            cyc++;
        end
        s_ready = 1'b0;
        chk("s_finish", 64'(s_finish), 64'd1);
        chk("s_tiles", 64'(idx), 64'd4);
        chk("s_valid_end", 64'(s_valid), 64'd0);

        // Single-tile instance (K=1)
        o_en = 1'b1;
        tick();
        o_en = 1'b0;
        chk("o_valid", 64'(o_valid), 64'd1);
        chk("o_row", 64'(o_row), 64'd0);
        chk("o_col", 64'(o_col), 64'd0);
        chk("o_data", 64'(o_data), 64'h807f01fe);
        tick();
        chk("o_hold", 64'(o_valid), 64'd1);
        chk("o_no_finish", 64'(o_finish), 64'd0);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("o_finish", 64'(o_finish), 64'd1);
        chk("o_valid_end", 64'(o_valid), 64'd0);
        chk("o_busy_end", 64'(o_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_tile_sel.md
# matrix_tile_sel

Parametrised tile streamer for the PE array. It captures an N×N matrix of signed DATA_W-bit elements on a start pulse and emits it as (N/T)² T×T tiles, one tile per accepted handshake, over a valid/ready interface. It sits between the weight-matrix source and the 16×16 PE tiles. It replaces fixed 16-output fan-out with one streamed tile port that supports backpressure.

## Interface
- DATA_W, 16, element width in bits (signed, two's complement)
- N, 64, matrix dimension (rows = cols)
- T, 16, tile dimension; N % T == 0 is required, else elaboration error
- K (localparam), N/T, tiles per row/column
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- en  in  1  start pulse; sampled only in IDLE
- matrix  in  N*N*DATA_W  element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W]; sampled on accepted en
- tile_valid  out  1  tile_data holds a valid tile
- tile_ready  in  1  consumer accepts the current tile
- tile_data  out  T*T*DATA_W  element (i,j) at [(i*T+j)*DATA_W +: DATA_W] = matrix(tr*T+i, tc*T+j)
- tile_row  out  $clog2(K) (min 1)  tr of the current tile
- tile_col  out  $clog2(K) (min 1)  tc of the current tile
- busy  out  1  high in SEND
- finish  out  1  sticky done flag

## Operation
- FSM has two states, IDLE and SEND.
- **IDLE:**
  - en=1: capture matrix into the internal buffer, set tr=tc=0, clear finish, go to SEND.
  - en=0: hold state.
- **SEND:**
  - tile_valid=1 and tile_data = tile (tr,tc).
  - A handshake (valid & ready) advances the index in row-major order: tc+1; at tc=K-1, tc wraps to 0 and tr+1.
  - A handshake on tile (K-1,K-1) sets finish=1, clears tile_valid and returns to IDLE.
- en during SEND is ignored. The buffer is never overwritten mid-stream.
- Without a handshake, tile_data, tile_row and tile_col are held stable while tile_valid=1.
- finish stays high until the next accepted en or rst.
- Data is a pure bit copy: no arithmetic and no sign extension.
- **Reset values:** state=IDLE, tile_valid=0, tile_data=0, tile_row=0, tile_col=0, busy=0, finish=0, buffer=0.
- **rst mid-stream:** the stream is abandoned, outputs return to reset values on the next edge, and no finish is produced.
- **K=1 (N==T):** a single tile; the first handshake sets finish.

## Timing
- Latency: en accepted at edge k → tile (0,0) on tile_valid/tile_data after edge k.
- All outputs are registered.
- Handshake at edge m → next tile visible after edge m, so throughput is one tile per cycle with ready held high.
- Minimum stream length is K² cycles from first valid to last handshake. finish is high after the edge of the last handshake, and busy falls on the same edge.
- en and the last handshake can never coincide; en is only sampled in IDLE.
- A new en in the cycle after finish rises is legal: finish clears and tile (0,0) of the new matrix appears one cycle later.

## Configuration
- MATRIX_TILE_COL_MAJOR_EN defined: traversal is column-major. tr advances first and tc advances when tr wraps. The last tile is still (K-1,K-1), and tile_row/tile_col report true coordinates.
- Undefined: row-major as described above.

## Structure
- Package matrix_tile_pkg holds:
  - the FSM state enum (ST_IDLE, ST_SEND)
  - the index-width function clog2_min1
  - the element-offset helper functions for matrix and tile packing
- Sub-module matrix_tile_extract is combinational. Parameters DATA_W, N, T; inputs buffer, tr, tc; output tile. It feeds the tile_data register.

## Test plan
- N=64, T=16, element (r,c) = r*64+c, ready held 1 → 16 tiles in order (0,0),(0,1)…(3,3) on consecutive cycles. Tile (1,2) element (0,0) = 16*64+32 = 1056. finish is high after the 16th handshake.
- N=8, T=4, DATA_W=8, ready toggling 1,0,0,1,… → 4 tiles total. tile_data and the indices stay stable through ready=0 cycles; no tile is duplicated or skipped.
- Negative data: all elements 16'h8000 → every tile_data word is 16'h8000, with no sign corruption.
- en pulsed during SEND with a different matrix → ignored; the original 16 tiles are emitted. A second en after finish streams the new matrix and clears finish.
- rst asserted after the 5th handshake → next cycle tile_valid=0, finish=0, busy=0, tile_data=0. Stream does not resume without a new en.
- MATRIX_TILE_COL_MAJOR_EN build, N=64, T=16 → order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3); finish after (3,3).
